stack_queue_param: RTL

//  Parametrised successor to the 3-entry stack machine: DEPTH-entry store, DATA_WIDTH-bit words, FIFO or LIFO order.

---
 rtl/stack_queue_pkg.sv | 32 +++
 rtl/stack_queue_param_if.sv | 38 +++
 rtl/stack_queue_param.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stack_queue_pkg.sv
// -----------------------------------------------------------------------------
// stack_queue_pkg
//   Shared definitions for the stack_queue_param store.
//   - push_mode_e : encodings of the i_push_mode field
//   - half_ext    : extracts the low or high half of a word, zero-extended
// No ports (package).
// -----------------------------------------------------------------------------
package stack_queue_pkg;

  typedef enum logic [1:0] {
    PUSH_FULL  = 2'b00,  // store the whole word
    PUSH_LO    = 2'b01,  // store low half, zero-extended
    PUSH_HI    = 2'b10,  // store high half, zero-extended
    PUSH_SPLIT = 2'b11   // store low half then high half as two entries
  } push_mode_e;

  // Widest word the helper below can handle; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH = 64;

  // Returns the selected half of data (half = half-width in bits), placed in
  // the low bits and zero-extended. Bits of data above 2*half must be zero.
  function automatic logic [MAX_DATA_WIDTH-1:0] half_ext(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input int unsigned               half,
    input logic                      hi
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = {MAX_DATA_WIDTH{1'b1}} >> (MAX_DATA_WIDTH - half);
    return (hi ? (data >> half) : data) & mask;
  endfunction

endpackage

// File: rtl/stack_queue_param_if.sv
// -----------------------------------------------------------------------------
// stack_queue_param_if
//   Host/consumer bus of the stack_queue_param store.
//   Requests : i_push, i_push_mode[1:0], i_pop, i_data[DATA_WIDTH]
//   Results  : o_data[DATA_WIDTH], o_data_valid
//   Status   : o_empty, o_full, o_wait, o_count[$clog2(DEPTH+1)], o_ovf, o_udf
//   modport master : driven by the host (requests out, results/status in)
//   modport slave  : the store itself (requests in, results/status out)
// -----------------------------------------------------------------------------
interface stack_queue_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  i_push;
  logic [1:0]            i_push_mode;
  logic                  i_pop;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_wait;
  logic [CW-1:0]         o_count;
  logic                  o_ovf;
  logic                  o_udf;

  modport master (
    output i_push, i_push_mode, i_pop, i_data,
    input  o_data, o_data_valid, o_empty, o_full, o_wait, o_count, o_ovf, o_udf
  );

  modport slave (
    input  i_push, i_push_mode, i_pop, i_data,
    output o_data, o_data_valid, o_empty, o_full, o_wait, o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/stack_queue_param.sv
// -----------------------------------------------------------------------------
// stack_queue_param
//   DEPTH-entry store of DATA_WIDTH-bit words in FIFO (LIFO=0) or LIFO (LIFO=1)
//   order. Push modes: full word, low half, high half, split (two entries).
//   Push and pop may happen in the same cycle; the pop sees pre-cycle contents.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears contents and status
//   bus    : stack_queue_param_if.slave (requests, registered read, status)
// Configuration
//   STACK_QUEUE_ERR_EN : when defined, o_ovf / o_udf are sticky flags set by a
//                        rejected push / pop; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module stack_queue_param
  import stack_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter bit LIFO       = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  stack_queue_param_if.slave  bus
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t           mem_reg [DEPTH];
  word_t           data_reg;
  logic            data_valid_reg;
  logic [CW-1:0]   count_reg;
  logic            empty_reg;
  logic            full_reg;
  logic            wait_reg;

  logic            pop_ok;
  logic            push_ok;
  logic            push_split;
  logic [CW-1:0]   push_n;
  logic [CW:0]     occ_after;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   pop_idx;
  logic [PW-1:0]   base_idx;
  logic [PW-1:0]   base_idx_p1;
  word_t           lo_word;
  word_t           hi_word;
  word_t           word0;
  word_t           word1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Acceptance: a pop is judged on the pre-cycle count only (no bypass from a
  // same-cycle push); a push must fit after the accepted pop has freed a slot.
  // One extra bit on occ_after keeps count+2 from wrapping.
  // ---------------------------------------------------------------------------
  assign push_split = (bus.i_push_mode == PUSH_SPLIT);
  assign push_n     = push_split ? CW'(2) : CW'(1);
  assign pop_ok     = bus.i_pop && (count_reg != '0);
  assign occ_after  = {1'b0, count_reg} - (CW + 1)'(pop_ok) + {1'b0, push_n};
  assign push_ok    = bus.i_push && (occ_after <= (CW + 1)'(DEPTH));
  assign count_next = count_reg - CW'(pop_ok) + (push_ok ? push_n : '0);

  // ---------------------------------------------------------------------------
  // Words to store. Split stores the low half first so that FIFO order yields
  // low-then-high and LIFO order yields high-then-low.
  // ---------------------------------------------------------------------------
  assign lo_word = word_t'(half_ext(MAX_DATA_WIDTH'(bus.i_data), HALF, 1'b0));
  assign hi_word = word_t'(half_ext(MAX_DATA_WIDTH'(bus.i_data), HALF, 1'b1));

  always_comb begin
    word0 = bus.i_data;
    word1 = '0;
    case (push_mode_e'(bus.i_push_mode))
      PUSH_FULL:  word0 = bus.i_data;
      PUSH_LO:    word0 = lo_word;
      PUSH_HI:    word0 = hi_word;
      PUSH_SPLIT: begin
        word0 = lo_word;
        word1 = hi_word;
      end
      default:    word0 = bus.i_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Addressing
  // ---------------------------------------------------------------------------
  generate
    if (LIFO) begin : g_lifo
      // The stack grows upward from entry 0; count is the next free slot.
      // After an accepted pop the old top is reused by a same-cycle push.
      assign pop_idx     = PW'(count_reg - CW'(1));
      assign base_idx    = PW'(count_reg - CW'(pop_ok));
      assign base_idx_p1 = base_idx + PW'(1);
    end else begin : g_fifo
      logic [PW-1:0] rd_ptr_reg;
      logic [PW-1:0] wr_ptr_reg;

      assign pop_idx     = rd_ptr_reg;
      assign base_idx    = wr_ptr_reg;
      assign base_idx_p1 = ptr_inc(wr_ptr_reg);

      // Circular pointers wrap explicitly at DEPTH, so any DEPTH works.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
        end else begin
          if (pop_ok) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          end
          if (push_ok) begin
            wr_ptr_reg <= push_split ? ptr_inc(base_idx_p1) : base_idx_p1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage, registered read port and status. Status flags are derived from
  // count_next so they always agree with the registered count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      count_reg      <= '0;
      empty_reg      <= 1'b1;
      full_reg       <= 1'b0;
      wait_reg       <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_reg[base_idx] <= word0;
        if (push_split) begin
          mem_reg[base_idx_p1] <= word1;
        end
      end
      // Reads the pre-cycle entry even when a push overwrites that slot.
      data_valid_reg <= pop_ok;
      if (pop_ok) begin
        data_reg <= mem_reg[pop_idx];
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
      wait_reg  <= (count_next > CW'(DEPTH - 2));
    end
  end

  assign bus.o_data       = data_reg;
  assign bus.o_data_valid = data_valid_reg;
  assign bus.o_count      = count_reg;
  assign bus.o_empty      = empty_reg;
  assign bus.o_full       = full_reg;
  assign bus.o_wait       = wait_reg;

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef STACK_QUEUE_ERR_EN
  logic ovf_reg;
  logic udf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (bus.i_push && !push_ok) begin
        ovf_reg <= 1'b1;
      end
      if (bus.i_pop && !pop_ok) begin
        udf_reg <= 1'b1;
      end
    end
  end

  assign bus.o_ovf = ovf_reg;
  assign bus.o_udf = udf_reg;
`else
  assign bus.o_ovf = 1'b0;
  assign bus.o_udf = 1'b0;
`endif

endmodule
